// File: rtl/rf_ctrl_pkg.sv
// Shared types for the integer register-file control blocks.
package rf_ctrl_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int ADDRW = $clog2(DEPTH);

  typedef logic [ADDRW-1:0] regaddr_t;
  typedef logic [WIDTH-1:0] regdata_t;

  typedef struct packed {
    regaddr_t wa;
    regdata_t wd;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer advances past each winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] cand;
  logic [PW-1:0] gnt_idx;
  logic          any;

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    any     = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr_q) + i) % N);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst) any = 1'b0;
    if (any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (any) begin
      ptr_q <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard for the integer register file.
// Optional macro RF_WB_BYPASS_EN adds a commit-cycle operand bypass.
module regfile_wb_sched
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int ADDRW   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid_i,
  input  logic [ADDRW-1:0]         iss_rd_i,
  output logic                     iss_ready_o,
  input  logic [2*ADDRW-1:0]       rd_ra_i,
  output logic [1:0]               hazard_o,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  input  logic [NUM_SRC*ADDRW-1:0] src_wa_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_wd_i,
  output logic [NUM_SRC-1:0]       src_ready_o,
`ifdef RF_WB_BYPASS_EN
  output logic [1:0]               byp_valid_o,
  output logic [2*WIDTH-1:0]       byp_data_o,
`endif
  output logic                     rf_we_o,
  output logic                     rf_wb_en_o,
  output logic [ADDRW-1:0]         rf_wa_o,
  output logic [WIDTH-1:0]         rf_wd_o,
  output logic [DEPTH-1:0]         pending_o
);

  logic [NUM_SRC-1:0] gnt;
  wb_req_t            sel;
  wb_req_t            wb_q;
  logic               we_q;
  logic [DEPTH-1:0]   pend_q;
  logic [DEPTH-1:0]   pend_d;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (src_valid_i),
    .gnt (gnt)
  );

  assign src_ready_o = gnt;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel.wa = src_wa_i[i*ADDRW +: ADDRW];
        sel.wd = src_wd_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      wb_q <= '0;
    end else if (|gnt) begin
      // A write to x0 is consumed here but never reaches the register file.
      we_q <= (sel.wa != '0);
      wb_q <= sel;
    end else begin
      we_q <= 1'b0;
    end
  end

  assign rf_we_o    = we_q;
  assign rf_wb_en_o = we_q;
  assign rf_wa_o    = wb_q.wa;
  assign rf_wd_o    = wb_q.wd;

  assign iss_ready_o = ~pend_q[iss_rd_i] | (iss_rd_i == '0);

  // Clear on commit first, then set, so a same-cycle reissue keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (we_q) pend_d[wb_q.wa] = 1'b0;
    if (iss_valid_i && iss_ready_o && (iss_rd_i != '0)) pend_d[iss_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a small flop bitmap and is reset; the register array itself lives elsewhere.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pending_o = pend_q;

  for (genvar k = 0; k < 2; k++) begin : g_rd
    logic [ADDRW-1:0] ra;
    logic             byp_hit;
    assign ra = rd_ra_i[k*ADDRW +: ADDRW];
`ifdef RF_WB_BYPASS_EN
    assign byp_hit                      = we_q && (ra == wb_q.wa) && (ra != '0);
    assign byp_valid_o[k]               = byp_hit;
    assign byp_data_o[k*WIDTH +: WIDTH] = wb_q.wd;
`else
    assign byp_hit = 1'b0;
`endif
    assign hazard_o[k] = pend_q[ra] && (ra != '0) && !byp_hit;
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed sequences, a vector
// table for scoreboard lookups, and randomized traffic against a model.
module tb_regfile_wb_sched;

  localparam int N = 3;
  localparam int W = 32;
  localparam int A = 5;
  localparam int D = 32;

  logic             clk;
  logic             rst;
  logic             iss_valid;
  logic [A-1:0]     iss_rd;
  logic             iss_ready;
  logic [2*A-1:0]   rd_ra;
  logic [1:0]       hazard;
  logic [N-1:0]     src_valid;
  logic [N*A-1:0]   src_wa;
  logic [N*W-1:0]   src_wd;
  logic [N-1:0]     src_ready;
  logic             rf_we;
  logic             rf_wb_en;
  logic [A-1:0]     rf_wa;
  logic [W-1:0]     rf_wd;
  logic [D-1:0]     pending;
`ifdef RF_WB_BYPASS_EN
  logic [1:0]       byp_valid;
  logic [2*W-1:0]   byp_data;
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_wb_sched dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .iss_ready_o (iss_ready),
    .rd_ra_i     (rd_ra),
    .hazard_o    (hazard),
    .src_valid_i (src_valid),
    .src_wa_i    (src_wa),
    .src_wd_i    (src_wd),
    .src_ready_o (src_ready),
`ifdef RF_WB_BYPASS_EN
    .byp_valid_o (byp_valid),
    .byp_data_o  (byp_data),
`endif
    .rf_we_o     (rf_we),
    .rf_wb_en_o  (rf_wb_en),
    .rf_wa_o     (rf_wa),
    .rf_wd_o     (rf_wd),
    .pending_o   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    iss_rd    = '0;
    rd_ra     = '0;
    src_valid = '0;
    src_wa    = '0;
    src_wd    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [A-1:0] wa, input logic [W-1:0] wd);
    src_valid[i]       = 1'b1;
    src_wa[i*A +: A]   = wa;
    src_wd[i*W +: W]   = wd;
  endtask

  task automatic issue(input logic [A-1:0] rd);
    iss_valid = 1'b1;
    iss_rd    = rd;
    tick();
    iss_valid = 1'b0;
  endtask

  typedef struct {
    logic [A-1:0] rd;
    logic [A-1:0] ra0;
    logic [A-1:0] ra1;
    logic         exp_ready;
    logic [1:0]   exp_hazard;
  } vec_t;

  vec_t vecs[6];

  // Reference model state
  bit [D-1:0]   m_pend;
  int           m_ptr;
  bit           m_we;
  bit [A-1:0]   m_wa;
  bit [W-1:0]   m_wd;
  bit           have [N];
  bit [A-1:0]   h_wa [N];
  bit [W-1:0]   h_wd [N];

  initial begin
    logic [2:0]   exp_g  [4];
    logic [A-1:0] exp_wa [4];
    logic [D-1:0] mask;

    // Pending set {7, 12}
    vecs[0] = '{rd: 5'd7,  ra0: 5'd7,  ra1: 5'd0,  exp_ready: 1'b0, exp_hazard: 2'b01};
    vecs[1] = '{rd: 5'd0,  ra0: 5'd0,  ra1: 5'd7,  exp_ready: 1'b1, exp_hazard: 2'b10};
    vecs[2] = '{rd: 5'd12, ra0: 5'd12, ra1: 5'd7,  exp_ready: 1'b0, exp_hazard: 2'b11};
    vecs[3] = '{rd: 5'd3,  ra0: 5'd3,  ra1: 5'd4,  exp_ready: 1'b1, exp_hazard: 2'b00};
    vecs[4] = '{rd: 5'd0,  ra0: 5'd0,  ra1: 5'd0,  exp_ready: 1'b1, exp_hazard: 2'b00};
    vecs[5] = '{rd: 5'd31, ra0: 5'd7,  ra1: 5'd12, exp_ready: 1'b1, exp_hazard: 2'b11};

    // Reset behaviour: no grant during the reset cycle, clean outputs after.
    idle();
    rst = 1'b1;
    src_valid = 3'b111;
    #1;
    check("rst_src_ready", 64'(src_ready), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    src_valid = '0;
    #1;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_wb_en", 64'(rf_wb_en), 64'd0);
    check("rst_rf_wa", 64'(rf_wa), 64'd0);
    check("rst_rf_wd", 64'(rf_wd), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);

    // Issue x5, write back through ALU, commit clears pending.
    issue(5'd5);
    check("iss5_pending", 64'(pending[5]), 64'd1);
    set_src(0, 5'd5, 32'hDEADBEEF);
    #1;
    check("wb5_grant", 64'(src_ready), 64'b001);
    tick();
    src_valid = '0;
    rd_ra = {5'd0, 5'd5};
    #1;
    check("wb5_we", 64'(rf_we), 64'd1);
    check("wb5_wb_en", 64'(rf_wb_en), 64'd1);
    check("wb5_wa", 64'(rf_wa), 64'd5);
    check("wb5_wd", 64'(rf_wd), 64'hDEADBEEF);
    check("wb5_commit_hazard", 64'(hazard), BYP ? 64'd0 : 64'd1);
    tick();
    check("wb5_cleared", 64'(pending[5]), 64'd0);
    check("wb5_we_drop", 64'(rf_we), 64'd0);
    check("wb5_hazard_gone", 64'(hazard), 64'd0);

    // Round-robin order with all three requesters busy.
    do_reset();
    exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_wa = '{5'd1, 5'd2, 5'd3, 5'd1};
    set_src(0, 5'd1, 32'h100);
    set_src(1, 5'd2, 32'h200);
    set_src(2, 5'd3, 32'h300);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr_grant%0d", c), 64'(src_ready), 64'(exp_g[c]));
      tick();
      check($sformatf("rr_wa%0d", c), 64'(rf_wa), 64'(exp_wa[c]));
      check($sformatf("rr_wd%0d", c), 64'(rf_wd), 64'(exp_wa[c]) << 8);
    end
    idle();

    // Scoreboard lookup table with x7 and x12 pending.
    do_reset();
    issue(5'd7);
    issue(5'd12);
    for (int v = 0; v < 6; v++) begin
      iss_rd = vecs[v].rd;
      rd_ra  = {vecs[v].ra1, vecs[v].ra0};
      #1;
      check($sformatf("tbl%0d_ready", v), 64'(iss_ready), 64'(vecs[v].exp_ready));
      check($sformatf("tbl%0d_hazard", v), 64'(hazard), 64'(vecs[v].exp_hazard));
      tick();
    end
    mask = (D'(1) << 7) | (D'(1) << 12);
    iss_rd = '0;
    iss_valid = 1'b1;
    #1;
    check("x0_issue_ready", 64'(iss_ready), 64'd1);
    tick();
    iss_valid = 1'b0;
    check("x0_issue_pending", 64'(pending), 64'(mask));

    // Commit to non-pending x9 coinciding with a new issue to x9: set wins.
    set_src(1, 5'd9, 32'h99);
    tick();
    src_valid = '0;
    iss_valid = 1'b1;
    iss_rd = 5'd9;
    #1;
    check("setwin_we", 64'(rf_we), 64'd1);
    check("setwin_wa", 64'(rf_wa), 64'd9);
    check("setwin_ready", 64'(iss_ready), 64'd1);
    tick();
    iss_valid = 1'b0;
    mask = mask | (D'(1) << 9);
    check("setwin_pending", 64'(pending), 64'(mask));

    // Write-back to x0 is consumed with no register-file write.
    set_src(2, 5'd0, 32'h55);
    #1;
    check("x0wb_grant", 64'(src_ready), 64'b100);
    tick();
    src_valid = '0;
    check("x0wb_we", 64'(rf_we), 64'd0);
    check("x0wb_wb_en", 64'(rf_wb_en), 64'd0);
    tick();
    check("x0wb_pending", 64'(pending), 64'(mask));

    // Reset while a write is being committed.
    set_src(0, 5'd7, 32'h77);
    tick();
    check("midrst_we_before", 64'(rf_we), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_src_ready", 64'(src_ready), 64'd0);
    tick();
    rst = 1'b0;
    src_valid = '0;
    #1;
    check("midrst_we", 64'(rf_we), 64'd0);
    check("midrst_wb_en", 64'(rf_wb_en), 64'd0);
    check("midrst_wa", 64'(rf_wa), 64'd0);
    check("midrst_wd", 64'(rf_wd), 64'd0);
    check("midrst_pending", 64'(pending), 64'd0);

`ifdef RF_WB_BYPASS_EN
    // Bypass of a committing write onto operand 1.
    do_reset();
    issue(5'd3);
    set_src(0, 5'd3, 32'h12);
    tick();
    src_valid = '0;
    rd_ra = {5'd3, 5'd0};
    #1;
    check("byp_hazard", 64'(hazard), 64'd0);
    check("byp_valid1", 64'(byp_valid[1]), 64'd1);
    check("byp_data1", 64'(byp_data[W +: W]), 64'h12);
    check("byp_valid0", 64'(byp_valid[0]), 64'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    m_pend = '0;
    m_ptr  = 0;
    m_we   = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
    for (int i = 0; i < N; i++) have[i] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int           g;
      bit           e_ready;
      bit   [1:0]   e_haz;
      bit   [A-1:0] ra [2];
      bit   [D-1:0] nxt;

      for (int i = 0; i < N; i++) begin
        if (!have[i] && ($urandom % 3 == 0)) begin
          have[i] = 1'b1;
          h_wa[i] = A'($urandom % 8);
          h_wd[i] = $urandom;
        end
        src_valid[i]     = have[i];
        src_wa[i*A +: A] = h_wa[i];
        src_wd[i*W +: W] = h_wd[i];
      end
      iss_valid = 1'($urandom % 2);
      iss_rd    = A'($urandom % 8);
      ra[0]     = A'($urandom % 8);
      ra[1]     = A'($urandom % 8);
      rd_ra     = {ra[1], ra[0]};
      #1;

      g = -1;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (g < 0 && have[j]) g = j;
      end
      e_ready = !m_pend[iss_rd] || (iss_rd == 0);
      for (int k = 0; k < 2; k++)
        e_haz[k] = m_pend[ra[k]] && (ra[k] != 0) && !(BYP && m_we && ra[k] == m_wa);

      check($sformatf("rnd_grant@%0d", cyc), 64'(src_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      check($sformatf("rnd_ready@%0d", cyc), 64'(iss_ready), 64'(e_ready));
      check($sformatf("rnd_hazard@%0d", cyc), 64'(hazard), 64'(e_haz));
      check($sformatf("rnd_we@%0d", cyc), 64'(rf_we), 64'(m_we));
      check($sformatf("rnd_wb_en@%0d", cyc), 64'(rf_wb_en), 64'(m_we));
      check($sformatf("rnd_pending@%0d", cyc), 64'(pending), 64'(m_pend));
      if (m_we) begin
        check($sformatf("rnd_wa@%0d", cyc), 64'(rf_wa), 64'(m_wa));
        check($sformatf("rnd_wd@%0d", cyc), 64'(rf_wd), 64'(m_wd));
      end
`ifdef RF_WB_BYPASS_EN
      for (int k = 0; k < 2; k++) begin
        bit hit;
        hit = m_we && (ra[k] == m_wa) && (ra[k] != 0);
        check($sformatf("rnd_byp_valid%0d@%0d", k, cyc), 64'(byp_valid[k]), 64'(hit));
        if (hit)
          check($sformatf("rnd_byp_data%0d@%0d", k, cyc), 64'(byp_data[k*W +: W]), 64'(m_wd));
      end
`endif

      nxt = m_pend;
      if (m_we) nxt[m_wa] = 1'b0;
      if (iss_valid && e_ready && iss_rd != 0) nxt[iss_rd] = 1'b1;
      m_pend = nxt;
      if (g >= 0) begin
        m_we    = (h_wa[g] != 0);
        m_wa    = h_wa[g];
        m_wd    = h_wd[g];
        m_ptr   = (g + 1) % N;
        have[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
